memory_arbiter: RTL
===================

# memory_arbiter

Two-to-one request arbiter placed directly upstream of the single-port memory/UART bus model. It accepts one-cycle request pulses from the core's instruction-fetch port and data port, holds each in a pending slot, and issues them one at a time onto the shared `memory_*` bus. It tags instruction accesses via `memory_instr` and routes each response back to the requester that owns it.

## Interface
Parameters:
- none: address 32 bits, data 32 bits, strobe 4 bits, fixed.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `imem_valid`  in  1  instruction request pulse, one cycle.
- `imem_addr`  in  32  instruction address.
- `imem_rdata`  out  32  instruction read data.
- `imem_ready`  out  1  instruction response strobe.
- `dmem_valid`  in  1  data request pulse, one cycle.
- `dmem_addr`  in  32  data address.
- `dmem_wdata`  in  32  data write value.
- `dmem_wstrb`  in  4  byte write enables; 0 means read.
- `dmem_rdata`  out  32  data read value.
- `dmem_ready`  out  1  data response strobe.
- `memory_valid`  out  1  issue pulse to memory, one cycle per request.
- `memory_instr`  out  1  1 = instruction access.
- `memory_addr`  out  32  address to memory.
- `memory_wdata`  out  32  write data to memory.
- `memory_wstrb`  out  4  byte enables to memory; forced 0 for instruction access.
- `memory_rdata`  in  32  memory read data.
- `memory_ready`  in  1  memory response strobe, one cycle.

## Operation
- Pending slots:
  - One slot per port: a valid bit plus the captured addr/wdata/wstrb.
  - A slot is loaded on any cycle its `*_valid` is 1.
  - A slot is cleared when its request is issued.
- State machine `IDLE`, `ISSUE`, `WAIT`; a 1-bit `owner` flag (0 = instr, 1 = data); a 1-bit `last` flag (last granted port).
- `IDLE`:
  - If any slot is pending, or a `*_valid` is high this cycle, grant and go to `ISSUE`.
  - The granted request is registered onto the `memory_*` outputs.
- `ISSUE`:
  - `memory_valid` = 1 for exactly this one cycle; go to `WAIT`.
- `WAIT`:
  - `memory_valid` = 0; memory outputs hold their values.
  - On `memory_ready` = 1, go to `IDLE`, or directly to `ISSUE` if another request is pending or arriving.
- Arbitration:
  - A single requester is granted immediately.
  - On a tie (both pending), round-robin: grant the port not equal to `last`.
  - `last` resets to instr, so the first tie goes to data.
- Response routing (combinational):
  - `imem_ready` = `memory_ready` & state==`WAIT` & owner==0.
  - `dmem_ready` = `memory_ready` & state==`WAIT` & owner==1.
  - `imem_rdata` = `dmem_rdata` = `memory_rdata`.
- Instruction access:
  - `memory_wstrb` = 0.
  - `memory_wdata` = 0.
  - `memory_instr` = 1.
- Requester contract: no new `*_valid` on a port until its previous `*_ready`. A violating pulse overwrites that port's slot if the slot is not yet issued; behaviour is otherwise undefined and need not be checked.
- Reset:
  - Values: state `IDLE`, slots cleared, `last` = instr, all `memory_*` outputs 0.
  - Reset mid-transaction abandons the request.
  - A `memory_ready` arriving in `IDLE` is ignored: no `*_ready` is produced.

## Timing
- Request pulse in cycle N, arbiter idle:
  - `memory_valid` high in cycle N+1.
  - Memory answers with `memory_ready` in N+2.
  - `*_ready` high in N+2.
  - Latency is 2 cycles.
- Back-to-back: the next request is issued in the cycle after `memory_ready`. Sustained throughput is one access per 2 cycles.
- Simultaneous `imem_valid` and `dmem_valid` in cycle N:
  - The winner issues at N+1 and completes at N+2.
  - The loser issues at N+3 and completes at N+4.
- A request arriving in the same cycle as `memory_ready` is eligible for issue at the next cycle, with no bubble.
- `memory_addr`/`wdata`/`wstrb`/`instr` are stable from the `ISSUE` cycle through the `memory_ready` cycle.
- The `*_ready` outputs are never high for both ports in the same cycle.

## Test plan
- Reset: hold `rst` 2 cycles with both valids high → all outputs 0, no `memory_valid` until the first request after `rst` falls.
- Instruction fetch: `imem_valid` with addr 0x100 in cycle N → `memory_valid` with `memory_instr`=1 and `memory_wstrb`=0 in N+1; `imem_ready` in N+2 with rdata = word 0x40 of memory.dat; `dmem_ready` stays 0.
- Data write then read: store 0xDEADBEEF, wstrb 0xF, to 0x200, then load 0x200 → second response rdata = 0xDEADBEEF; a byte store (wstrb 0x2, wdata 0x0000AA00) then read → only byte 1 changes.
- Tie: both valids in the same cycle after reset → data completes at N+2, instr at N+4. Repeat the tie → instr is granted first.
- Streaming: imem pulses every 2 cycles with continuous dmem traffic → alternating grants, no lost or duplicated response, each `*_ready` count equals its request count.
- Reset mid-op: assert `rst` in the `WAIT` cycle, with the memory delivering `memory_ready` next cycle → no `*_ready` asserted; the next request completes normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-to-one request arbiter in front of a single-port memory bus.
// Captures one-cycle request pulses from the instruction-fetch and data ports into
// per-port pending slots, issues them one at a time on the memory_* bus with
// round-robin tie-breaking, and routes each memory response back to its owner.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_valid/addr          instruction request pulse and address
//   imem_rdata/ready         instruction response data and strobe
//   dmem_valid/addr/wdata/   data request pulse, address, write value,
//   dmem_wstrb               byte enables (0 = read)
//   dmem_rdata/ready         data response data and strobe
//   memory_valid/instr/addr/ issue pulse, instruction tag, address,
//   memory_wdata/wstrb       write value and byte enables toward memory
//   memory_rdata/ready       memory response data and strobe
module memory_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e        state_q;
  logic          owner_q;   // 0 = instr, 1 = data
  logic          last_q;    // last granted port

  logic          i_pend_q;
  logic [AW-1:0] i_addr_q;
  logic          d_pend_q;
  logic [AW-1:0] d_addr_q;
  logic [DW-1:0] d_wdata_q;
  logic [SW-1:0] d_wstrb_q;

  logic          mem_valid_q;
  logic          mem_instr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [SW-1:0] mem_wstrb_q;

  logic          i_req_d;
  logic          d_req_d;
  logic [AW-1:0] i_addr_d;
  logic [AW-1:0] d_addr_d;
  logic [DW-1:0] d_wdata_d;
  logic [SW-1:0] d_wstrb_d;
  logic          can_grant_d;
  logic          issue_d;
  logic          grant_d;   // 0 = instr, 1 = data

  // Arbitration: a pulse arriving this cycle is as eligible as a held slot.
  always_comb begin
    i_req_d     = i_pend_q | imem_valid;
    d_req_d     = d_pend_q | dmem_valid;
    i_addr_d    = imem_valid ? imem_addr  : i_addr_q;
    d_addr_d    = dmem_valid ? dmem_addr  : d_addr_q;
    d_wdata_d   = dmem_valid ? dmem_wdata : d_wdata_q;
    d_wstrb_d   = dmem_valid ? dmem_wstrb : d_wstrb_q;
    can_grant_d = (state_q == IDLE) | ((state_q == WAIT) & memory_ready);
    issue_d     = can_grant_d & (i_req_d | d_req_d);
    grant_d     = 1'b0;
    if (i_req_d && d_req_d) begin
      grant_d = ~last_q;
    end else begin
      grant_d = d_req_d;
    end
  end

  // State, slots and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      i_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_pend_q    <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wstrb_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      if (imem_valid) begin
        i_pend_q <= 1'b1;
        i_addr_q <= imem_addr;
      end
      if (dmem_valid) begin
        d_pend_q  <= 1'b1;
        d_addr_q  <= dmem_addr;
        d_wdata_q <= dmem_wdata;
        d_wstrb_q <= dmem_wstrb;
      end

      mem_valid_q <= issue_d;

      if (issue_d) begin
        state_q     <= ISSUE;
        owner_q     <= grant_d;
        last_q      <= grant_d;
        mem_instr_q <= ~grant_d;
        mem_addr_q  <= grant_d ? d_addr_d  : i_addr_d;
        // Instruction accesses never write.
        mem_wdata_q <= grant_d ? d_wdata_d : DW'(0);
        mem_wstrb_q <= grant_d ? d_wstrb_d : SW'(0);
        // Clearing the granted slot overrides a same-cycle load of it.
        if (grant_d) begin
          d_pend_q <= 1'b0;
        end else begin
          i_pend_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ISSUE:   state_q <= WAIT;
          WAIT:    if (memory_ready) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign memory_valid = mem_valid_q;
  assign memory_instr = mem_instr_q;
  assign memory_addr  = mem_addr_q;
  assign memory_wdata = mem_wdata_q;
  assign memory_wstrb = mem_wstrb_q;

  // Responses are only accepted while waiting; a stray ready in IDLE is dropped.
  assign imem_ready = memory_ready & (state_q == WAIT) & ~owner_q;
  assign dmem_ready = memory_ready & (state_q == WAIT) &  owner_q;
  assign imem_rdata = memory_rdata;
  assign dmem_rdata = memory_rdata;

endmodule
